// File: rtl/dgiota_pkg.sv
// Shared definitions for the digital-OTA trim calibrator.
//   dgiota_cal_state_e  : calibration FSM states
//   DGIOTA_SYNC_STAGES  : depth of the comparator synchroniser
//   dgiota_midscale()   : reset / abort value of a trim code of a given width
package dgiota_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_TRIAL,
        ST_SETTLE,
        ST_SAMPLE,
        ST_DONE
    } dgiota_cal_state_e;

    localparam int DGIOTA_SYNC_STAGES = 2;

    function automatic logic [31:0] dgiota_midscale(input int width);
        return 32'd1 << (width - 1);
    endfunction

endpackage

// File: rtl/dgiota_sync.sv
// W-wide multi-flop synchroniser for the asynchronous comparator outputs.
//   clk  : system clock
//   rst  : asynchronous active-high clear
//   d_i  : asynchronous inputs
//   q_o  : synchronised outputs (DGIOTA_SYNC_STAGES cycles of latency)
module dgiota_sync
    import dgiota_pkg::*;
#(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [W-1:0] d_i,
    output logic [W-1:0] q_o
);

    logic [DGIOTA_SYNC_STAGES-1:0][W-1:0] ff_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ff_q <= '0;
        end else begin
            ff_q[0] <= d_i;
            for (int i = 1; i < DGIOTA_SYNC_STAGES; i++) begin
                ff_q[i] <= ff_q[i-1];
            end
        end
    end

    assign q_o = ff_q[DGIOTA_SYNC_STAGES-1];

endmodule

// File: rtl/dgiota_trim_cal.sv
// N-channel SAR offset-trim calibrator for digital-cell OTAs.
// Channels are calibrated one after another; each trim code is found MSB
// first by setting a trial bit, waiting S cycles, then clearing the bit if
// the (synchronised) comparator says the OTA output is above the reference.
//
// Ports:
//   clk, rst    : clock, asynchronous active-high reset
//   start       : begin calibration of all channels (ignored while busy)
//   abort       : terminate calibration (wins over start in IDLE)
//   settle_cfg  : settle cycles per trial bit, clamped to >= 2, latched at start
//   cmp_in      : asynchronous comparator outputs, one per channel
//   trim        : trim codes, channel c at [c*TRIM_W +: TRIM_W]
//   cal_mode    : high while calibrating
//   chan_sel    : channel under calibration (0 when not busy)
//   busy        : calibration in progress
//   done        : one-cycle pulse on successful completion
//
// Build option DGIOTA_MAJ_EN: the sample phase lasts 3 cycles and the bit
// decision is a 2-of-3 majority of consecutive synchronised comparator values.
module dgiota_trim_cal
    import dgiota_pkg::*;
#(
    parameter int NCH      = 4,
    parameter int TRIM_W   = 6,
    parameter int SETTLE_W = 4,
    localparam int CH_W    = (NCH > 1) ? $clog2(NCH) : 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic                  abort,
    input  logic [SETTLE_W-1:0]   settle_cfg,
    input  logic [NCH-1:0]        cmp_in,
    output logic [NCH*TRIM_W-1:0] trim,
    output logic                  cal_mode,
    output logic [CH_W-1:0]       chan_sel,
    output logic                  busy,
    output logic                  done
);

    localparam int BIT_W = $clog2(TRIM_W);
    // Counter must hold the clamp value 2 even for a 1-bit settle_cfg.
    localparam int CNT_W = (SETTLE_W < 2) ? 2 : SETTLE_W;

    localparam logic [TRIM_W-1:0] MID      = TRIM_W'(dgiota_midscale(TRIM_W));
    localparam logic [BIT_W-1:0]  BIT_MSB  = BIT_W'(TRIM_W - 1);
    localparam logic [CH_W-1:0]   CH_LAST  = CH_W'(NCH - 1);
    localparam logic [CNT_W-1:0]  SET_MIN  = CNT_W'(2);

    dgiota_cal_state_e state_q, state_d;
    logic [CH_W-1:0]   ch_q, ch_d;
    logic [BIT_W-1:0]  bit_q, bit_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [CNT_W-1:0]  settle_q, settle_d;
    logic [NCH-1:0][TRIM_W-1:0] trim_q;

    logic              trim_we;
    logic [TRIM_W-1:0] trim_wd;
    logic              take;
    logic              decision;
    logic [CNT_W-1:0]  cfg_ext;
    logic [NCH-1:0]    cmp_s;

`ifdef DGIOTA_MAJ_EN
    logic [1:0] samp_q, samp_d;
    logic [1:0] hist_q;
`endif

    dgiota_sync #(.W(NCH)) u_sync (
        .clk (clk),
        .rst (rst),
        .d_i (cmp_in),
        .q_o (cmp_s)
    );

    assign busy     = (state_q == ST_TRIAL) || (state_q == ST_SETTLE) ||
                      (state_q == ST_SAMPLE);
    assign cal_mode = busy;
    assign done     = (state_q == ST_DONE);
    assign chan_sel = busy ? ch_q : '0;
    assign trim     = trim_q;
    assign cfg_ext  = CNT_W'(settle_cfg);

    always_comb begin
        state_d  = state_q;
        ch_d     = ch_q;
        bit_d    = bit_q;
        cnt_d    = cnt_q;
        settle_d = settle_q;
        trim_we  = 1'b0;
        trim_wd  = trim_q[ch_q];
        take     = 1'b0;
        decision = 1'b0;
`ifdef DGIOTA_MAJ_EN
        samp_d   = samp_q;
`endif

        case (state_q)
            ST_IDLE: begin
                if (start && !abort) begin
                    state_d  = ST_TRIAL;
                    ch_d     = '0;
                    bit_d    = BIT_MSB;
                    settle_d = (cfg_ext < SET_MIN) ? SET_MIN : cfg_ext;
                end
            end
            ST_TRIAL: begin
                trim_we = 1'b1;
                // MSB trial also wipes the lower bits left from a prior run.
                if (bit_q == BIT_MSB) trim_wd = MID;
                else                  trim_wd[bit_q] = 1'b1;
                cnt_d   = settle_q - 1'b1;
                state_d = ST_SETTLE;
            end
            ST_SETTLE: begin
                if (cnt_q == '0) state_d = ST_SAMPLE;
                else             cnt_d   = cnt_q - 1'b1;
            end
            ST_SAMPLE: begin
`ifdef DGIOTA_MAJ_EN
                if (samp_q != 2'd2) begin
                    samp_d = samp_q + 1'b1;
                end else begin
                    samp_d   = '0;
                    take     = 1'b1;
                    decision = (hist_q[0] & hist_q[1]) | (hist_q[0] & cmp_s[ch_q]) |
                               (hist_q[1] & cmp_s[ch_q]);
                end
`else
                take     = 1'b1;
                decision = cmp_s[ch_q];
`endif
                if (take) begin
                    if (decision) begin
                        trim_we        = 1'b1;
                        trim_wd[bit_q] = 1'b0;
                    end
                    if (bit_q != '0) begin
                        bit_d   = bit_q - 1'b1;
                        state_d = ST_TRIAL;
                    end else if (ch_q != CH_LAST) begin
                        ch_d    = ch_q + 1'b1;
                        bit_d   = BIT_MSB;
                        state_d = ST_TRIAL;
                    end else begin
                        state_d = ST_DONE;
                    end
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase

        // Abort drops the half-searched channel back to midscale.
        if (abort && busy) begin
            state_d = ST_IDLE;
            ch_d    = '0;
            trim_we = 1'b1;
            trim_wd = MID;
`ifdef DGIOTA_MAJ_EN
            samp_d  = '0;
`endif
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            ch_q     <= '0;
            bit_q    <= '0;
            cnt_q    <= '0;
            settle_q <= SET_MIN;
            trim_q   <= {NCH{MID}};
        end else begin
            state_q  <= state_d;
            ch_q     <= ch_d;
            bit_q    <= bit_d;
            cnt_q    <= cnt_d;
            settle_q <= settle_d;
            if (trim_we) trim_q[ch_q] <= trim_wd;
        end
    end

`ifdef DGIOTA_MAJ_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            samp_q <= '0;
            hist_q <= '0;
        end else begin
            samp_q <= samp_d;
            if (state_q == ST_SAMPLE && samp_q != 2'd2) hist_q[samp_q[0]] <= cmp_s[ch_q];
        end
    end
`endif

endmodule

// File: tb/tb_dgiota_trim_cal.sv
module tb_dgiota_trim_cal;

    localparam int NCH = 4;
    localparam int TW  = 6;
    localparam int SW  = 4;
`ifdef DGIOTA_MAJ_EN
    localparam int  EXTRA = 4;
    localparam bit  MAJ   = 1'b1;
`else
    localparam int  EXTRA = 2;
    localparam bit  MAJ   = 1'b0;
`endif
    localparam logic [TW-1:0] MID = TW'(1 << (TW - 1));

    logic                clk = 1'b0;
    logic                rst = 1'b1;
    logic                start = 1'b0;
    logic                abort = 1'b0;
    logic [SW-1:0]       settle_cfg = '0;
    logic [NCH-1:0]      cmp_in;
    logic [NCH*TW-1:0]   trim;
    logic                cal_mode;
    logic [1:0]          chan_sel;
    logic                busy;
    logic                done;

    dgiota_trim_cal #(.NCH(NCH), .TRIM_W(TW), .SETTLE_W(SW)) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .abort      (abort),
        .settle_cfg (settle_cfg),
        .cmp_in     (cmp_in),
        .trim       (trim),
        .cal_mode   (cal_mode),
        .chan_sel   (chan_sel),
        .busy       (busy),
        .done       (done)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Comparator model: OTA output above reference when trim exceeds target.
    logic [TW-1:0]  tgt [NCH];
    logic [NCH-1:0] glitch = '0;
    always_comb begin
        for (int c = 0; c < NCH; c++) cmp_in[c] = (trim[c*TW +: TW] > tgt[c]) ^ glitch[c];
    end

    typedef struct {
        int                rise;
        int                fall;
        bit                dn;
        logic [NCH*TW-1:0] trims;
    } exp_t;
    exp_t exp_q[$];

    int errors = 0;
    int checks = 0;
    int run_c0 = 0;
    int run_bitc = 1;
    bit run_active = 1'b0;
    logic [NCH*TW-1:0] hold;

    // Successive approximation at the arithmetic level: keep each weight
    // whose addition does not push the code past the target.
    function automatic logic [TW-1:0] sar_model(input int target);
        int code = 0;
        for (int b = TW - 1; b >= 0; b--) if (code + (1 << b) <= target) code += (1 << b);
        return TW'(code);
    endfunction

    task automatic chk(input string name, input longint act, input longint req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // Monitor: pops the scoreboard whenever a calibration ends (busy falls).
    initial begin
        bit prev_busy = 1'b0;
        int rise_c = -1;
        exp_t e;
        forever begin
            @(negedge clk);
            if (rst) begin
                prev_busy = 1'b0;
            end else begin
                if (busy && !prev_busy) rise_c = cyc;
                if (cal_mode !== busy) chk("cal_mode_vs_busy", longint'(cal_mode), longint'(busy));
                if (busy && run_active)
                    chk("chan_sel", longint'(chan_sel), longint'(((cyc - run_c0 - 1) / run_bitc) / TW));
                if (done && !prev_busy) chk("spurious_done", 1, 0);
                if (!busy && prev_busy) begin
                    if (exp_q.size() == 0) begin
                        chk("unexpected_end", 1, 0);
                    end else begin
                        e = exp_q.pop_front();
                        chk("busy_rise_cycle", longint'(rise_c), longint'(e.rise));
                        chk("end_cycle", longint'(cyc), longint'(e.fall));
                        chk("done_at_end", longint'(done), longint'(e.dn));
                        chk("trims", longint'(trim), longint'(e.trims));
                    end
                end
                prev_busy = busy;
            end
        end
    end

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_trim"}, longint'(trim), longint'({NCH{MID}}));
        chk({tag, "_outs"}, longint'({cal_mode, busy, done, chan_sel}), 0);
    endtask

    task automatic run(input int scfg, input int abort_at, input int rst_at, input bit poke);
        int S, c0, bitc, total, abch, gsel, j, pos;
        bit ended = 1'b0;
        logic [NCH*TW-1:0] ex;
        exp_t e;
        @(negedge clk);
        settle_cfg = SW'(scfg);
        start      = 1'b1;
        c0         = cyc;
        S          = (scfg < 2) ? 2 : scfg;
        bitc       = S + EXTRA;
        total      = NCH * TW * bitc;
        run_c0     = c0;
        run_bitc   = bitc;
        run_active = 1'b1;
        abch       = (abort_at > 0) ? ((abort_at - 1) / bitc) / TW : NCH;
        ex         = hold;
        for (int c = 0; c < NCH; c++) begin
            if (c < abch)       ex[c*TW +: TW] = sar_model(int'(tgt[c]));
            else if (c == abch) ex[c*TW +: TW] = MID;
        end
        if (rst_at < 0) begin
            e.rise  = c0 + 1;
            e.fall  = (abort_at > 0) ? c0 + abort_at + 1 : c0 + total + 1;
            e.dn    = (abort_at <= 0);
            e.trims = ex;
            exp_q.push_back(e);
        end
        gsel = 0;
        for (int k = 1; k <= total + 20; k++) begin
            @(negedge clk);
            start = poke && (k == 50);
            if (poke && k == 30) settle_cfg = SW'(scfg + 5);
            abort = (k == abort_at);
            glitch = '0;
            if (MAJ) begin
                j   = (k - 1) / bitc;
                pos = (k - 1) % bitc;
                if (pos == 0) gsel = $urandom_range(0, 2);
                if (j < NCH * TW && pos == S - 1 + gsel) glitch[j / TW] = 1'b1;
            end
            if (k == rst_at) begin
                rst = 1'b1;
                #1 check_reset_outputs("rst_async");
                @(negedge clk);
                check_reset_outputs("rst_held");
                rst = 1'b0;
                ended = 1'b1;
                break;
            end
            if (!busy) begin
                ended = 1'b1;
                break;
            end
        end
        start = 1'b0;
        abort = 1'b0;
        glitch = '0;
        settle_cfg = SW'(scfg);
        run_active = 1'b0;
        if (!ended) begin
            chk("run_timeout", 1, 0);
            exp_q.delete();
        end
        hold = (rst_at > 0) ? {NCH{MID}} : ex;
    endtask

    initial begin
        int r;
        for (int c = 0; c < NCH; c++) tgt[c] = '0;
        hold = {NCH{MID}};
        repeat (2) @(negedge clk);
        check_reset_outputs("reset");
        rst = 1'b0;
        @(negedge clk);
        check_reset_outputs("post_reset");

        // Normal run with a start pulse and a settle_cfg change mid-run.
        tgt = '{6'h15, 6'h00, 6'h3F, 6'h20};
        run(3, -1, -1, 1'b1);

        // Settle clamp.
        tgt = '{6'h2A, 6'h2A, 6'h2A, 6'h2A};
        run(0, -1, -1, 1'b0);

        // Random targets and settle values.
        for (int i = 0; i < 3; i++) begin
            for (int c = 0; c < NCH; c++) tgt[c] = TW'($urandom);
            run($urandom_range(0, 6), -1, -1, 1'b0);
        end

        // Abort in cycle 40, then at a random point.
        for (int c = 0; c < NCH; c++) tgt[c] = TW'($urandom);
        run(3, 40, -1, 1'b0);
        for (int c = 0; c < NCH; c++) tgt[c] = TW'($urandom);
        r = $urandom_range(2, 5);
        run(r, $urandom_range(1, NCH * TW * (r + EXTRA)), -1, 1'b0);

        // start and abort together in IDLE: stays idle.
        @(negedge clk);
        start = 1'b1;
        abort = 1'b1;
        @(negedge clk);
        start = 1'b0;
        abort = 1'b0;
        chk("start_abort_idle_1", longint'(busy), 0);
        @(negedge clk);
        chk("start_abort_idle_2", longint'({busy, cal_mode, done}), 0);
        chk("start_abort_trims", longint'(trim), longint'(hold));

        // Reset mid-run, then a fresh normal run.
        tgt = '{6'h15, 6'h00, 6'h3F, 6'h20};
        run(3, -1, 60, 1'b0);
        run(3, -1, -1, 1'b0);

        repeat (3) @(negedge clk);
        chk("scoreboard_empty", longint'(exp_q.size()), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
